axil_dotp_engine: RTL and testbench

- Parametrised successor to the fixed-width dot-product controller.
- AXI-Lite slave with a register file and two on-chip vector buffers (A, B) of DEPTH elements each.
- A pipelined signed/unsigned multiply-accumulate engine computes sum(A[i]*B[i]) for a programmable length.
- Sits between the system AXI-Lite interconnect and the accelerator core; it replaces the separate fetch/compute/store/read done-handshakes with one self-timed engine plus a status register and an interrupt.

---
 rtl/axil_dotp_engine_if.sv | 34 +++
 rtl/axil_dotp_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_axil_dotp_engine.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_dotp_engine_if.sv
// AXI-Lite slave bundle for the dot-product engine; the slave modport is the engine side.
interface axil_dotp_engine_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axil_dotp_engine.sv
// AXI-Lite register file with two vector buffers and a self-timed pipelined
// multiply-accumulate engine computing sum(A[i]*B[i]) over a programmable length.
module axil_dotp_engine #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int SIGNED = 1,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  axil_dotp_engine_if.slave s,
  output logic              irq
);
  localparam int ACC_W = 2*DATA_W + $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef enum logic [2:0] {SEL_CTRL, SEL_STATUS, SEL_LEN, SEL_RLO, SEL_RHI,
                            SEL_A, SEL_B, SEL_NONE} sel_e;

  logic [DATA_W-1:0] buf_a [DEPTH];
  logic [DATA_W-1:0] buf_b [DEPTH];

  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q, rdata_q, rd_word;
  logic              awready_q, wready_q, bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q, rd_resp;
  logic              irq_en, done, err, start_req;
  logic [6:0]        len, run_len;
  logic signed [ACC_W-1:0] result, acc, prod_p1;
  logic [63:0]       res64;
  state_e            state, state_nxt;
  logic [IDX_W-1:0]  idx, widx, ridx;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              vld_p0, vld_p1, last_p0, last_p1;
  logic              busy, len_ok, run_go, err_go, issue, last_issue, finish;
  logic              commit, w_slverr;
  sel_e              wsel, rsel;
  logic              unused;

  function automatic sel_e decode(input logic [ADDR_W-3:0] wa);
    logic [ADDR_W-9:0] page;
    logic [5:0]        word;
    sel_e              sel;
    page = wa[ADDR_W-3:6];
    word = wa[5:0];
    sel  = SEL_NONE;
    if (page == '0) begin
      case (word)
        6'd0:    sel = SEL_CTRL;
        6'd1:    sel = SEL_STATUS;
        6'd2:    sel = SEL_LEN;
        6'd3:    sel = SEL_RLO;
        6'd4:    sel = SEL_RHI;
        default: sel = SEL_NONE;
      endcase
    end else if (int'(word) < DEPTH) begin
      if (page == (ADDR_W-8)'(1))      sel = SEL_A;
      else if (page == (ADDR_W-8)'(2)) sel = SEL_B;
    end
    return sel;
  endfunction

  function automatic logic [31:0] ext_elem(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return 32'($signed(v));
    return 32'(v);
  endfunction

  function automatic logic [63:0] ext_res(input logic signed [ACC_W-1:0] r);
    if (SIGNED != 0) return 64'(r);
    return 64'($unsigned(r));
  endfunction

  // One extra operand bit lets a single signed multiplier serve both modes.
  function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0]     ax, bx;
    logic signed [2*DATA_W+1:0] p;
    ax = (SIGNED != 0) ? {a[DATA_W-1], a} : {1'b0, a};
    bx = (SIGNED != 0) ? {b[DATA_W-1], b} : {1'b0, b};
    p  = ax * bx;
    return ACC_W'(p);
  endfunction

  assign busy     = (state != IDLE);
  assign len_ok   = (len != 7'd0) && (int'(len) <= DEPTH);
  assign commit   = ~awready_q & ~wready_q & ~bvalid_q;
  assign wsel     = decode(awaddr_q[ADDR_W-1:2]);
  assign widx     = awaddr_q[IDX_W+1:2];
  assign w_slverr = (wsel == SEL_NONE) || (((wsel == SEL_A) || (wsel == SEL_B)) && busy);
  assign rsel     = decode(s.s_araddr[ADDR_W-1:2]);
  assign ridx     = s.s_araddr[IDX_W+1:2];
  assign res64    = ext_res(result);
  assign unused   = ^{s.s_wstrb, awaddr_q, wdata_q, s.s_araddr};

  assign s.s_awready = awready_q;
  assign s.s_wready  = wready_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = ~rvalid_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
  assign irq         = done & irq_en;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    run_go     = 1'b0;
    err_go     = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    finish     = vld_p1 & last_p1;
    case (state)
      IDLE: if (start_req) begin
        if (len_ok) begin
          run_go    = 1'b1;
          state_nxt = RUN;
        end else begin
          err_go = 1'b1;
        end
      end
      RUN: begin
        issue      = 1'b1;
        last_issue = (7'(idx) == run_len - 7'd1);
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      idx     <= '0;
      run_len <= '0;
    end else begin
      vld_p0  <= issue;
      last_p0 <= last_issue;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (run_go) begin
        idx     <= '0;
        run_len <= len;
      end else if (issue) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s.s_awvalid && awready_q) awaddr_q <= s.s_awaddr;
    if (s.s_wvalid && wready_q)   wdata_q  <= s.s_wdata;
    if (commit && !busy && wsel == SEL_A) buf_a[widx] <= wdata_q[DATA_W-1:0];
    if (commit && !busy && wsel == SEL_B) buf_b[widx] <= wdata_q[DATA_W-1:0];
    // p0: buffer read
    if (issue) begin
      a_p0 <= buf_a[idx];
      b_p0 <= buf_b[idx];
    end
    // p1: registered product
    if (vld_p0) prod_p1 <= mul_ext(a_p0, b_p0);
    // accumulate
    if (run_go)      acc <= '0;
    else if (vld_p1) acc <= acc + prod_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      start_req <= 1'b0;
      result    <= '0;
    end else begin
      start_req <= 1'b0;
      if (s.s_awvalid && awready_q) awready_q <= 1'b0;
      if (s.s_wvalid && wready_q)   wready_q  <= 1'b0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_slverr ? 2'b10 : 2'b00;
        case (wsel)
          SEL_CTRL: begin
            irq_en <= wdata_q[2];
            if (wdata_q[1] && !busy) begin
              done   <= 1'b0;
              err    <= 1'b0;
              result <= '0;
            end
            if (wdata_q[0] && !busy) start_req <= 1'b1;
          end
          SEL_STATUS: begin
            if (wdata_q[1]) done <= 1'b0;
            if (wdata_q[2]) err  <= 1'b0;
          end
          SEL_LEN: len <= wdata_q[6:0];
          default: ;
        endcase
      end
      if (bvalid_q && s.s_bready) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
      // Engine events come last so a completion beats a same-cycle W1C.
      if (err_go) begin
        err  <= 1'b1;
        done <= 1'b1;
      end
      if (finish) begin
        done   <= 1'b1;
        result <= acc + prod_p1;
      end
      if (s.s_arvalid && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s.s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = 2'b00;
    case (rsel)
      SEL_CTRL:   rd_word = {29'd0, irq_en, 2'b00};
      SEL_STATUS: rd_word = {29'd0, err, done, busy};
      SEL_LEN:    rd_word = {25'd0, len};
      SEL_RLO:    rd_word = res64[31:0];
      SEL_RHI:    rd_word = res64[63:32];
      SEL_A:      if (busy) rd_resp = 2'b10; else rd_word = ext_elem(buf_a[ridx]);
      SEL_B:      if (busy) rd_resp = 2'b10; else rd_word = ext_elem(buf_b[ridx]);
      default:    rd_resp = 2'b10;
    endcase
  end
endmodule

// File: tb/tb_axil_dotp_engine.sv
// Directed bench for axil_dotp_engine: register table, engine runs, error paths,
// handshake corner cases and reset during a run.
module tb_axil_dotp_engine;
  logic clk = 1'b0;
  logic rst;
  logic irq;
  always #5 clk = ~clk;

  axil_dotp_engine_if #(.ADDR_W(12)) bus ();

  axil_dotp_engine #(.DATA_W(16), .DEPTH(16), .SIGNED(1), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .s(bus), .irq(irq)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_rise = -1;
  int bv_rise = -1;
  int bv_count = 0;
  logic irq_prev = 1'b0;
  logic bv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (irq && !irq_prev) irq_rise = cyc;
    irq_prev = irq;
    if (bus.s_bvalid && !bv_prev) begin
      bv_rise = cyc;
      bv_count++;
    end
    bv_prev = bus.s_bvalid;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, output logic [1:0] resp);
    bit aw_f, w_f, b_f, fin;
    fin = 0;
    resp = 2'b11;
    @(negedge clk);
    bus.s_awaddr = addr; bus.s_awvalid = 1'b1;
    bus.s_wdata = data;  bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1;
    for (int t = 0; t < 40 && !fin; t++) begin
      aw_f = bus.s_awvalid && bus.s_awready;
      w_f  = bus.s_wvalid && bus.s_wready;
      b_f  = bus.s_bvalid && bus.s_bready;
      if (b_f) resp = bus.s_bresp;
      @(negedge clk);
      if (aw_f) bus.s_awvalid = 1'b0;
      if (w_f)  bus.s_wvalid = 1'b0;
      if (b_f)  fin = 1;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h", addr);
    end
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_f, r_f, fin;
    fin = 0;
    data = '0;
    resp = 2'b11;
    @(negedge clk);
    bus.s_araddr = addr; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
    for (int t = 0; t < 40 && !fin; t++) begin
      ar_f = bus.s_arvalid && bus.s_arready;
      r_f  = bus.s_rvalid && bus.s_rready;
      if (r_f) begin
        data = bus.s_rdata;
        resp = bus.s_rresp;
      end
      @(negedge clk);
      if (ar_f) bus.s_arvalid = 1'b0;
      if (r_f)  fin = 1;
    end
    bus.s_arvalid = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h", addr);
    end
  endtask

  task automatic wr_exp(input string name, input logic [11:0] addr, input logic [31:0] data,
                        input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, r);
    check(name, 64'(r), 64'(exp_resp));
  endtask

  task automatic rd_exp(input string name, input logic [11:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check(name, {30'd0, r, d}, {30'd0, exp_resp, exp_data});
  endtask

  task automatic start_run(input logic [31:0] ctrl, output int commit_cyc);
    irq_rise = -1;
    wr_exp("start", 12'h000, ctrl, 2'b00);
    commit_cyc = bv_rise;
  endtask

  task automatic wait_irq(input string name, input int base, input int lat);
    for (int t = 0; t < 100 && irq_rise < 0; t++) @(negedge clk);
    check(name, 64'(irq_rise - base), 64'(lat));
  endtask

  initial begin
    int c0;
    logic [1:0] r;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = 4'hF;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    rst = 1'b1;

    vecs[0]  = '{1'b0, 12'h004, 32'h0,        2'b00, 32'h0};
    vecs[1]  = '{1'b0, 12'h008, 32'h0,        2'b00, 32'h0};
    vecs[2]  = '{1'b0, 12'h00C, 32'h0,        2'b00, 32'h0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        2'b00, 32'h0};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,        2'b00, 32'h0};
    vecs[5]  = '{1'b1, 12'h008, 32'hFFFFFFFF, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 12'h008, 32'h0,        2'b00, 32'h0000007F};
    vecs[7]  = '{1'b1, 12'h000, 32'h4,        2'b00, 32'h0};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        2'b00, 32'h4};
    vecs[9]  = '{1'b1, 12'h300, 32'h1,        2'b10, 32'h0};
    vecs[10] = '{1'b0, 12'h300, 32'h0,        2'b10, 32'h0};
    vecs[11] = '{1'b0, 12'h014, 32'h0,        2'b10, 32'h0};
    vecs[12] = '{1'b1, 12'h10C, 32'h8001,     2'b00, 32'h0};
    vecs[13] = '{1'b0, 12'h10C, 32'h0,        2'b00, 32'hFFFF8001};
    vecs[14] = '{1'b1, 12'h23C, 32'hABCD1234, 2'b00, 32'h0};
    vecs[15] = '{1'b0, 12'h23C, 32'h0,        2'b00, 32'h00001234};
    vecs[16] = '{1'b0, 12'h140, 32'h0,        2'b10, 32'h0};
    vecs[17] = '{1'b1, 12'h240, 32'h5,        2'b10, 32'h0};

    repeat (2) @(negedge clk);
    check("reset_hs", {58'd0, bus.s_awready, bus.s_wready, bus.s_arready,
                       bus.s_bvalid, bus.s_rvalid, irq}, 64'b111000);
    check("reset_resp", {28'd0, bus.s_bresp, bus.s_rresp, bus.s_rdata}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) wr_exp($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data, vecs[i].resp);
      else            rd_exp($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp);
    end

    // Basic run: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      wr_exp("ld_a", 12'h100 + 12'(4*i), 32'(i + 1), 2'b00);
      wr_exp("ld_b", 12'h200 + 12'(4*i), 32'(i + 5), 2'b00);
    end
    wr_exp("len4", 12'h008, 32'd4, 2'b00);
    start_run(32'h5, c0);
    rd_exp("basic_busy", 12'h004, 32'h1, 2'b00);
    wait_irq("basic_done_lat", c0, 7);
    rd_exp("basic_status", 12'h004, 32'h2, 2'b00);
    rd_exp("basic_lo", 12'h00C, 32'd70, 2'b00);
    rd_exp("basic_hi", 12'h010, 32'd0, 2'b00);
    check("basic_irq", 64'(irq), 64'd1);
    wr_exp("w1c_done", 12'h004, 32'h2, 2'b00);
    check("basic_irq_clr", 64'(irq), 64'd0);

    // Signed run: -3*4 + 2*-5 = -22
    wr_exp("ld_a", 12'h100, 32'hFFFD, 2'b00);
    wr_exp("ld_a", 12'h104, 32'h0002, 2'b00);
    wr_exp("ld_b", 12'h200, 32'h0004, 2'b00);
    wr_exp("ld_b", 12'h204, 32'hFFFB, 2'b00);
    wr_exp("len2", 12'h008, 32'd2, 2'b00);
    start_run(32'h5, c0);
    wait_irq("signed_done_lat", c0, 5);
    rd_exp("signed_lo", 12'h00C, 32'hFFFFFFEA, 2'b00);
    rd_exp("signed_hi", 12'h010, 32'hFFFFFFFF, 2'b00);
    wr_exp("w1c_done", 12'h004, 32'h2, 2'b00);

    // Full depth at max positive, with bus traffic while busy
    for (int i = 0; i < 16; i++) begin
      wr_exp("ld_a", 12'h100 + 12'(4*i), 32'h7FFF, 2'b00);
      wr_exp("ld_b", 12'h200 + 12'(4*i), 32'h7FFF, 2'b00);
    end
    wr_exp("len16", 12'h008, 32'd16, 2'b00);
    start_run(32'h5, c0);
    wr_exp("busy_buf_wr", 12'h100, 32'h1234, 2'b10);
    rd_exp("busy_buf_rd", 12'h100, 32'h0, 2'b10);
    wr_exp("busy_start", 12'h000, 32'h5, 2'b00);
    wait_irq("full_done_lat", c0, 19);
    rd_exp("full_lo", 12'h00C, 32'hFFF00010, 2'b00);
    rd_exp("full_hi", 12'h010, 32'h00000003, 2'b00);
    rd_exp("buf_unchanged", 12'h100, 32'h00007FFF, 2'b00);
    rd_exp("busy_start_ignored", 12'h004, 32'h2, 2'b00);
    wr_exp("w1c_done", 12'h004, 32'h6, 2'b00);

    // Illegal lengths
    wr_exp("len0", 12'h008, 32'd0, 2'b00);
    start_run(32'h5, c0);
    wait_irq("len0_err_lat", c0, 1);
    rd_exp("len0_status", 12'h004, 32'h6, 2'b00);
    rd_exp("len0_result_kept", 12'h00C, 32'hFFF00010, 2'b00);
    wr_exp("w1c_all", 12'h004, 32'h6, 2'b00);
    rd_exp("w1c_status", 12'h004, 32'h0, 2'b00);
    wr_exp("len17", 12'h008, 32'd17, 2'b00);
    start_run(32'h5, c0);
    wait_irq("len17_err_lat", c0, 1);
    rd_exp("len17_status", 12'h004, 32'h6, 2'b00);
    rd_exp("len17_result_kept", 12'h010, 32'h3, 2'b00);

    // soft_clr wipes done, err and RESULT
    wr_exp("soft_clr", 12'h000, 32'h6, 2'b00);
    rd_exp("soft_clr_status", 12'h004, 32'h0, 2'b00);
    rd_exp("soft_clr_result", 12'h00C, 32'h0, 2'b00);
    check("soft_clr_irq", 64'(irq), 64'd0);

    // W leads AW by three cycles, then B is back-pressured
    begin
      int n0;
      n0 = bv_count;
      @(negedge clk);
      bus.s_wdata = 32'd3; bus.s_wvalid = 1'b1; bus.s_bready = 1'b0;
      @(negedge clk);
      bus.s_wvalid = 1'b0;
      check("w_early_wready", 64'(bus.s_wready), 64'd0);
      repeat (2) @(negedge clk);
      check("w_early_no_b", 64'(bus.s_bvalid), 64'd0);
      bus.s_awaddr = 12'h008; bus.s_awvalid = 1'b1;
      @(negedge clk);
      bus.s_awvalid = 1'b0;
      check("aw_late_no_b", {62'd0, bus.s_awready, bus.s_bvalid}, 64'd0);
      @(negedge clk);
      check("b_after_aw", {61'd0, bus.s_bvalid, bus.s_bresp}, 64'b100);
      repeat (5) begin
        @(negedge clk);
        check("b_held", {61'd0, bus.s_bvalid, bus.s_bresp}, 64'b100);
      end
      bus.s_bready = 1'b1;
      @(negedge clk);
      bus.s_bready = 1'b0;
      check("ready_restore", {61'd0, bus.s_bvalid, bus.s_awready, bus.s_wready}, 64'b011);
      check("single_b", 64'(bv_count - n0), 64'd1);
      rd_exp("late_aw_len", 12'h008, 32'd3, 2'b00);
    end

    // Reset in the middle of a run
    wr_exp("len16", 12'h008, 32'd16, 2'b00);
    start_run(32'h5, c0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_hs", {58'd0, bus.s_awready, bus.s_wready, bus.s_arready,
                         bus.s_bvalid, bus.s_rvalid, irq}, 64'b111000);
    rst = 1'b0;
    irq_rise = -1;
    rd_exp("rst_mid_status", 12'h004, 32'h0, 2'b00);
    repeat (30) @(negedge clk);
    check("rst_mid_no_irq", 64'(irq), 64'd0);
    rd_exp("rst_mid_no_done", 12'h004, 32'h0, 2'b00);
    wr_exp("len2", 12'h008, 32'd2, 2'b00);
    start_run(32'h5, c0);
    wait_irq("post_rst_lat", c0, 5);
    rd_exp("post_rst_lo", 12'h00C, 32'h7FFE0002, 2'b00);
    rd_exp("post_rst_hi", 12'h010, 32'h0, 2'b00);

    axi_write(12'h004, 32'h6, r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
